// File: rtl/term_cursor_ctrl.sv
// term_cursor_ctrl: turns a UART byte stream into text-RAM writes plus cursor and scroll state.
// Latency: printable write appears 2 cycles after i_RX_DV; clears write one cell per cycle, lagging o_Busy by one cycle.
// Backpressure: none upstream; one pending byte is held while busy, further bytes are dropped and flagged on o_Overrun.
// Ports: i_Clock/i_Reset; i_RX_DV/i_RX_Byte from the receiver; o_Wr_En/o_Wr_Addr/o_Wr_Data to the text RAM;
//        o_Cursor_Col/o_Cursor_Row/o_Top_Row cursor and scroll offset; o_Busy clear in progress; o_Overrun sticky drop.
module term_cursor_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 24
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_Wr_En,
  output logic [10:0] o_Wr_Addr,
  output logic [7:0]  o_Wr_Data,
  output logic [6:0]  o_Cursor_Col,
  output logic [4:0]  o_Cursor_Row,
  output logic [4:0]  o_Top_Row,
  output logic        o_Busy,
  output logic        o_Overrun
);

  localparam int          CELLS      = COLS * ROWS;
  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [5:0]  ROWS_W     = 6'(ROWS);
  localparam logic [10:0] COLS_W     = 11'(COLS);
  localparam logic [10:0] LAST_COL_W = 11'(COLS - 1);
  localparam logic [10:0] LAST_CELL  = 11'(CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_EXEC       = 2'd1,
    S_CLR_LINE   = 2'd2,
    S_CLR_SCREEN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        overrun_q, overrun_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  top_q, top_d;
  logic [10:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        do_nl;

  // Physical row of the cursor: top + row wraps at most once, so one subtract suffices.
  logic [5:0]  row_sum;
  logic [4:0]  phys_row;
  logic [10:0] row_base;
  assign row_sum  = {1'b0, top_q} + {1'b0, row_q};
  assign phys_row = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W) : row_sum[4:0];
  assign row_base = {6'd0, phys_row} * COLS_W;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    do_nl      = 1'b0;

    // Byte intake: IDLE starts the pending byte first so arrival order is kept.
    if (state_q == S_IDLE) begin
      if (pend_vld_q) begin
        cur_d   = pend_q;
        state_d = S_EXEC;
        if (i_RX_DV) pend_d = i_RX_Byte;
        else         pend_vld_d = 1'b0;
      end else if (i_RX_DV) begin
        cur_d   = i_RX_Byte;
        state_d = S_EXEC;
      end
    end else if (i_RX_DV) begin
      if (pend_vld_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d     = i_RX_Byte;
        pend_vld_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        state_d = S_IDLE;
        if (cur_q >= 8'h20 && cur_q <= 8'h7E) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base + {4'd0, col_q};
          wr_data_d = cur_q;
          if (col_q == LAST_COL) begin
            col_d = 7'd0;
            do_nl = 1'b1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else if (cur_q == 8'h0A) begin
          do_nl = 1'b1;
        end else if (cur_q == 8'h0D) begin
          col_d = 7'd0;
        end else if (cur_q == 8'h08) begin
          if (col_q != 7'd0) col_d = col_q - 7'd1;
        end else if (cur_q == 8'h0C) begin
          col_d   = 7'd0;
          row_d   = 5'd0;
          top_d   = 5'd0;
          cnt_d   = 11'd0;
          state_d = S_CLR_SCREEN;
        end
        if (do_nl) begin
          if (row_q != LAST_ROW) begin
            row_d = row_q + 5'd1;
          end else begin
            // Scroll: the old top row becomes the new bottom row and is blanked.
            top_d   = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
            cnt_d   = 11'd0;
            state_d = S_CLR_LINE;
          end
        end
      end
      S_CLR_LINE: begin
        // top_q is already advanced, so row_base points at the new bottom row.
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + cnt_q;
        wr_data_d = 8'h20;
        if (cnt_q == LAST_COL_W) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + 11'd1;
      end
      S_CLR_SCREEN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = 8'h20;
        if (cnt_q == LAST_CELL) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + 11'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cur_q      <= 8'd0;
      pend_q     <= 8'd0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
      top_q      <= 5'd0;
      cnt_q      <= 11'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 11'd0;
      wr_data_q  <= 8'd0;
    end else begin
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Cursor_Col = col_q;
  assign o_Cursor_Row = row_q;
  assign o_Top_Row    = top_q;
  assign o_Busy       = (state_q == S_CLR_LINE) || (state_q == S_CLR_SCREEN);
  assign o_Overrun    = overrun_q;

endmodule

// File: doc/term_cursor_ctrl.md
TERM_CURSOR_CTRL -- requirements
Module: term_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row; legal range 2..128.
REQ-002 SHALL have parameter ROWS, default 24, meaning text rows on screen; legal range 2..32, with COLS*ROWS <= 2048.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_RX_DV, input, 1 bit: received-byte strobe, one cycle per byte, from the UART receiver.
REQ-006 SHALL have port i_RX_Byte, input, 8 bits: received byte, valid while i_RX_DV is 1.
REQ-007 SHALL have port o_Wr_En, output, 1 bit: text-RAM write strobe, one cycle per write.
REQ-008 SHALL have port o_Wr_Addr, output, 11 bits: text-RAM address = phys_row*COLS + col.
REQ-009 SHALL have port o_Wr_Data, output, 8 bits: character code to write.
REQ-010 SHALL have port o_Cursor_Col, output, 7 bits: logical cursor column.
REQ-011 SHALL have port o_Cursor_Row, output, 5 bits: logical cursor row, where 0 is the top visible row.
REQ-012 SHALL have port o_Top_Row, output, 5 bits: physical RAM row shown as logical row 0 (scroll offset).
REQ-013 SHALL have port o_Busy, output, 1 bit: a line or screen clear is in progress.
REQ-014 SHALL have port o_Overrun, output, 1 bit: sticky flag; a byte was dropped.

Function
REQ-015 SHALL compute phys_row = (o_Top_Row + o_Cursor_Row) mod ROWS, using compare-and-subtract with no divider.
REQ-016 SHALL implement states IDLE, EXEC, CLR_LINE and CLR_SCREEN, and SHALL return to IDLE from any unused encoding.
REQ-017 SHALL, in IDLE with i_RX_DV=1 (or a pending byte held), latch the byte and enter EXEC on the next cycle.
REQ-018 SHALL, for a printable byte 0x20..0x7E in EXEC: assert o_Wr_En for exactly one cycle with o_Wr_Data=byte and o_Wr_Addr at the current cursor; the cursor update is visible the following cycle; write latency is 2 cycles after the i_RX_DV cycle.
REQ-019 SHALL, after a printable write with col<COLS-1, increment col; with col=COLS-1, set col=0 and perform a newline.
REQ-020 SHALL handle newline (LF 0x0A, or auto-wrap): row<ROWS-1 -> row+1 and back to IDLE; row=ROWS-1 -> row unchanged, o_Top_Row=(o_Top_Row+1) mod ROWS, enter CLR_LINE.
REQ-021 SHALL, in CLR_LINE, write 0x20 to the COLS addresses of the new bottom physical row, column 0..COLS-1, one per cycle, then return to IDLE.
REQ-022 SHALL handle CR 0x0D by setting col=0, with no write.
REQ-023 SHALL handle BS 0x08 as col-1 if col>0, else no change; no write.
REQ-024 SHALL handle FF 0x0C by setting cursor (0,0) and o_Top_Row=0, then entering CLR_SCREEN, which writes 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle.
REQ-025 SHALL ignore all other byte values: no write and no cursor change.
REQ-026 SHALL hold o_Busy at 1 for every cycle in CLR_LINE or CLR_SCREEN, and at 0 otherwise.
REQ-027 SHALL store a byte arriving while not in IDLE in a one-entry pending register, executed when IDLE is next reached.
REQ-028 SHALL, when a byte arrives while the pending register is full, drop the new byte and set o_Overrun=1; the flag is cleared only by reset.
REQ-029 SHALL, when a byte arrives in the same cycle a clear completes, place it in pending with no loss.
REQ-030 SHALL keep o_Wr_En=0 in every cycle other than the write cycles given in REQ-018, REQ-021 and REQ-024.

Reset
REQ-031 SHALL, while i_Reset=1, force: state IDLE, o_Wr_En=0, o_Wr_Addr=0, o_Wr_Data=0, o_Cursor_Col=0, o_Cursor_Row=0, o_Top_Row=0, o_Busy=0, o_Overrun=0, pending empty.
REQ-032 SHALL abort any clear in progress on reset, with no further writes; RAM contents are not cleared by reset.
REQ-033 SHALL ignore i_RX_DV in any cycle where i_Reset=1.

Verification
REQ-034 SHALL pass: reset, then 0x41 -> one write with addr 0 and data 0x41 two cycles after i_RX_DV; cursor becomes (col 1, row 0).
REQ-035 SHALL pass: 80 bytes 0x58 from (0,0) -> last write at addr 79; cursor becomes (0,1); no clear occurs.
REQ-036 SHALL pass: 24 LF bytes from (0,0) -> row 23 after the 23rd; the 24th gives o_Top_Row=1, 80 writes of 0x20 at addr 0..79, and o_Busy high for exactly 80 cycles.
REQ-037 SHALL pass: 0x0C -> 1920 writes of 0x20 at addr 0..1919; cursor (0,0); o_Top_Row=0.
REQ-038 SHALL pass: three bytes sent during CLR_SCREEN -> the 1st byte is executed after the clear, the 2nd and 3rd are dropped, and o_Overrun=1.
REQ-039 SHALL pass: BS at col 0 gives no change; reset asserted mid-CLR_SCREEN stops writes immediately and all outputs take their reset values.
